// File: rtl/ddr_init_refresh_sched.sv
// DDR SDRAM power-up/mode-register init sequencer plus auto-refresh scheduler and bus arbiter.
// Optional DDR_REFRESH_STATS_EN adds the stat_ref_count / stat_max_pending outputs.
module ddr_init_refresh_sched #(
    parameter int          INIT_WAIT_CYCLES = 20000,
    parameter int          TRP_CYCLES       = 2,
    parameter int          TMRD_CYCLES      = 2,
    parameter int          TRFC_CYCLES      = 7,
    parameter int          DLL_LOCK_CYCLES  = 200,
    parameter int          REFI_CYCLES      = 780,
    parameter int          MAX_POSTPONE     = 8,
    parameter logic [13:0] MODE_REG         = 14'h0021,
    parameter logic [13:0] EXT_MODE_REG     = 14'h0000
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_urgent,
    input  logic        ref_grant,
    output logic        ref_busy,
    output logic        ref_overflow,
    output logic        cmd_valid,
    output logic        cmd_ras_n,
    output logic        cmd_cas_n,
    output logic        cmd_we_n,
    output logic [1:0]  cmd_ba,
    output logic [13:0] cmd_a,
    output logic        cke
`ifdef DDR_REFRESH_STATS_EN
    ,
    output logic [31:0] stat_ref_count,
    output logic [3:0]  stat_max_pending
`endif
);

    localparam int MAX_A   = (INIT_WAIT_CYCLES > DLL_LOCK_CYCLES) ? INIT_WAIT_CYCLES : DLL_LOCK_CYCLES;
    localparam int MAX_B   = (TRFC_CYCLES > TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES;
    localparam int MAX_C   = (MAX_B > TRP_CYCLES) ? MAX_B : TRP_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(REFI_CYCLES + 1);

    localparam logic [2:0]  CMD_NOP = 3'b111;
    localparam logic [2:0]  CMD_PRE = 3'b010;
    localparam logic [2:0]  CMD_REF = 3'b001;
    localparam logic [2:0]  CMD_MRS = 3'b000;
    localparam logic [13:0] A10_ALL = 14'h0400;
    localparam logic [3:0]  MAX_P   = 4'(MAX_POSTPONE);

    typedef enum logic [3:0] {
        RST_WAIT, CKE_NOP, PRE1, EMRS, MRS_DLLRST, PRE2, REF1, REF2,
        MRS, DLL_WAIT, IDLE, RPRE, RREF, RWAIT
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [TMR_W-1:0]  timer;
    logic [3:0]        pending;
    logic              valid_n, cke_n, init_done_n, busy_n, dec, expire;
    logic [2:0]        code_n;
    logic [1:0]        ba_n;
    logic [13:0]       a_n;

    assign ref_req    = (pending != 4'd0);
    assign ref_urgent = (pending == MAX_P);
    assign expire     = init_done && (timer == TMR_W'(REFI_CYCLES - 1));

    // Each command state is entered with cnt=0 on the cycle its command issues;
    // the next command issues exactly when cnt reaches that command's spacing-1.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        valid_n     = 1'b0;
        code_n      = CMD_NOP;
        ba_n        = 2'b00;
        a_n         = '0;
        cke_n       = cke;
        init_done_n = init_done;
        busy_n      = ref_busy;
        dec         = 1'b0;
        case (state)
            RST_WAIT: if (cnt == CNT_W'(INIT_WAIT_CYCLES)) begin
                cke_n = 1'b1; state_n = CKE_NOP; cnt_n = '0;
            end
            CKE_NOP: begin
                valid_n = 1'b1; code_n = CMD_PRE; a_n = A10_ALL; state_n = PRE1; cnt_n = '0;
            end
            PRE1: if (cnt == CNT_W'(TRP_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_MRS; ba_n = 2'b01; a_n = EXT_MODE_REG;
                state_n = EMRS; cnt_n = '0;
            end
            EMRS: if (cnt == CNT_W'(TMRD_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_MRS; a_n = MODE_REG | 14'h0100;
                state_n = MRS_DLLRST; cnt_n = '0;
            end
            MRS_DLLRST: if (cnt == CNT_W'(TMRD_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_PRE; a_n = A10_ALL; state_n = PRE2; cnt_n = '0;
            end
            PRE2: if (cnt == CNT_W'(TRP_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_REF; state_n = REF1; cnt_n = '0;
            end
            REF1: if (cnt == CNT_W'(TRFC_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_REF; state_n = REF2; cnt_n = '0;
            end
            REF2: if (cnt == CNT_W'(TRFC_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_MRS; a_n = MODE_REG; state_n = MRS; cnt_n = '0;
            end
            // cnt keeps running into DLL_WAIT so the lock time counts from the final MRS
            MRS: if (cnt == CNT_W'(TMRD_CYCLES - 1)) state_n = DLL_WAIT;
            DLL_WAIT: if (cnt == CNT_W'(DLL_LOCK_CYCLES - 1)) begin
                state_n = IDLE; init_done_n = 1'b1; busy_n = 1'b0; cnt_n = '0;
            end
            IDLE: if (ref_req && ref_grant) begin
                state_n = RPRE; busy_n = 1'b1; cnt_n = '0;
            end
            RPRE: begin
                valid_n = 1'b1; code_n = CMD_PRE; a_n = A10_ALL; state_n = RREF; cnt_n = '0;
            end
            RREF: if (cnt == CNT_W'(TRP_CYCLES - 1)) begin
                valid_n = 1'b1; code_n = CMD_REF; dec = 1'b1; state_n = RWAIT; cnt_n = '0;
            end
            RWAIT: if (cnt == CNT_W'(TRFC_CYCLES - 1)) begin
                if (ref_req && ref_grant) begin
                    valid_n = 1'b1; code_n = CMD_REF; dec = 1'b1; cnt_n = '0;
                end else begin
                    state_n = IDLE; busy_n = 1'b0; cnt_n = '0;
                end
            end
            default: begin
                state_n = RST_WAIT; cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= RST_WAIT;
            cnt       <= '0;
            cke       <= 1'b0;
            init_done <= 1'b0;
            ref_busy  <= 1'b1;
            cmd_valid <= 1'b0;
            {cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_a     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cke       <= cke_n;
            init_done <= init_done_n;
            ref_busy  <= busy_n;
            cmd_valid <= valid_n;
            {cmd_ras_n, cmd_cas_n, cmd_we_n} <= code_n;
            cmd_ba    <= ba_n;
            cmd_a     <= a_n;
        end
    end

    // An expiry at the ceiling is lost (overflow); a simultaneous issue cancels it out.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            timer        <= '0;
            pending      <= '0;
            ref_overflow <= 1'b0;
        end else begin
            if (init_done) timer <= expire ? '0 : timer + TMR_W'(1);
            if (expire && pending == MAX_P) ref_overflow <= 1'b1;
            if (expire && !dec && pending != MAX_P) pending <= pending + 4'd1;
            else if (dec && !expire)               pending <= pending - 4'd1;
        end
    end

`ifdef DDR_REFRESH_STATS_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_ref_count   <= '0;
            stat_max_pending <= '0;
        end else begin
            if (dec) stat_ref_count <= stat_ref_count + 32'd1;
            if (pending > stat_max_pending) stat_max_pending <= pending;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_init_refresh_sched.sv
// Directed bench for ddr_init_refresh_sched: init timing, refresh scheduling, postpone/overflow, reset abort.
module tb_ddr_init_refresh_sched;

    logic        clk = 1'b0;
    logic        nreset;
    logic        ref_grant;
    logic        init_done, ref_req, ref_urgent, ref_busy, ref_overflow;
    logic        cmd_valid, cmd_ras_n, cmd_cas_n, cmd_we_n, cke;
    logic [1:0]  cmd_ba;
    logic [13:0] cmd_a;
`ifdef DDR_REFRESH_STATS_EN
    logic [31:0] stat_ref_count;
    logic [3:0]  stat_max_pending;
`endif

    ddr_init_refresh_sched #(
        .INIT_WAIT_CYCLES(10),
        .TRP_CYCLES(2),
        .TMRD_CYCLES(2),
        .TRFC_CYCLES(7),
        .DLL_LOCK_CYCLES(20),
        .REFI_CYCLES(50),
        .MAX_POSTPONE(3),
        .MODE_REG(14'h0021),
        .EXT_MODE_REG(14'h0000)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .init_done(init_done),
        .ref_req(ref_req),
        .ref_urgent(ref_urgent),
        .ref_grant(ref_grant),
        .ref_busy(ref_busy),
        .ref_overflow(ref_overflow),
        .cmd_valid(cmd_valid),
        .cmd_ras_n(cmd_ras_n),
        .cmd_cas_n(cmd_cas_n),
        .cmd_we_n(cmd_we_n),
        .cmd_ba(cmd_ba),
        .cmd_a(cmd_a),
        .cke(cke)
`ifdef DDR_REFRESH_STATS_EN
        ,
        .stat_ref_count(stat_ref_count),
        .stat_max_pending(stat_max_pending)
`endif
    );

    always #5 clk = ~clk;

    // Cycle index: 0 is the first edge sampling nreset=1; -1 while in reset.
    int cyc = -1;
    always @(posedge clk) cyc <= nreset ? cyc + 1 : -1;

    localparam logic [18:0] C_PRE     = {3'b010, 2'b00, 14'h0400};
    localparam logic [18:0] C_REF     = {3'b001, 2'b00, 14'h0000};
    localparam logic [18:0] C_EMRS    = {3'b000, 2'b01, 14'h0000};
    localparam logic [18:0] C_MRS_DLL = {3'b000, 2'b00, 14'h0121};
    localparam logic [18:0] C_MRS     = {3'b000, 2'b00, 14'h0021};

    typedef struct {
        int          c;
        logic [18:0] code;
    } cmd_t;
    cmd_t cmd_q[$];
    cmd_t exp_q[$];

    always @(negedge clk)
        if (cmd_valid) cmd_q.push_back('{c: cyc, code: {cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_a}});

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int t);
        int guard = 0;
        while (cyc != t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) check_val("wait_timeout", cyc, t);
    endtask

    task automatic expect_cmd(input int c, input logic [18:0] code);
        exp_q.push_back('{c: c, code: code});
    endtask

    task automatic check_cmds(input string pfx);
        check_val({pfx, "_count"}, cmd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cmd_q.size()) begin
                check_val($sformatf("%s%0d_cycle", pfx, i), cmd_q[i].c, exp_q[i].c);
                check_val($sformatf("%s%0d_code", pfx, i), cmd_q[i].code, exp_q[i].code);
            end
        end
        cmd_q.delete();
        exp_q.delete();
    endtask

    task automatic check_init(input string pfx);
        wait_to(9);
        check_val({pfx, "_cke_low"}, cke, 1'b0);
        wait_to(10);
        check_val({pfx, "_cke_high"}, cke, 1'b1);
        wait_to(52);
        check_val({pfx, "_done_early"}, init_done, 1'b0);
        check_val({pfx, "_busy_init"}, ref_busy, 1'b1);
        wait_to(53);
        check_val({pfx, "_done"}, init_done, 1'b1);
        check_val({pfx, "_busy_off"}, ref_busy, 1'b0);
        check_val({pfx, "_req_off"}, ref_req, 1'b0);
        expect_cmd(11, C_PRE);
        expect_cmd(13, C_EMRS);
        expect_cmd(15, C_MRS_DLL);
        expect_cmd(17, C_PRE);
        expect_cmd(19, C_REF);
        expect_cmd(26, C_REF);
        expect_cmd(33, C_MRS);
        check_cmds({pfx, "_cmd"});
    endtask

    initial begin
        nreset    = 1'b0;
        ref_grant = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cke", cke, 1'b0);
        check_val("rst_init_done", init_done, 1'b0);
        check_val("rst_busy", ref_busy, 1'b1);
        check_val("rst_req", ref_req, 1'b0);
        check_val("rst_urgent", ref_urgent, 1'b0);
        check_val("rst_overflow", ref_overflow, 1'b0);
        check_val("rst_valid", cmd_valid, 1'b0);
        check_val("rst_cmd", {cmd_ras_n, cmd_cas_n, cmd_we_n}, 3'b111);
        check_val("rst_ba", cmd_ba, 2'b00);
        check_val("rst_a", cmd_a, 14'h0000);
        cmd_q.delete();
        nreset = 1'b1;

        check_init("init");

        // Single refresh with grant held high
        wait_to(102);
        check_val("ref_req_early", ref_req, 1'b0);
        wait_to(103);
        check_val("ref_req_rise", ref_req, 1'b1);
        check_val("ref_busy_pre", ref_busy, 1'b0);
        wait_to(104);
        check_val("ref_busy_rise", ref_busy, 1'b1);
        check_val("ref_no_cmd_yet", cmd_valid, 1'b0);
        wait_to(107);
        check_val("ref_req_cleared", ref_req, 1'b0);
        wait_to(113);
        check_val("ref_busy_hold", ref_busy, 1'b1);
        wait_to(114);
        check_val("ref_busy_fall", ref_busy, 1'b0);
        ref_grant = 1'b0;
        expect_cmd(105, C_PRE);
        expect_cmd(107, C_REF);
        check_cmds("ref1_cmd");

        // Postponed refreshes with grant withheld
        wait_to(152);
        check_val("post_req_early", ref_req, 1'b0);
        wait_to(153);
        check_val("post_req", ref_req, 1'b1);
        wait_to(252);
        check_val("post_urgent_early", ref_urgent, 1'b0);
        wait_to(253);
        check_val("post_urgent", ref_urgent, 1'b1);
        wait_to(302);
        check_val("post_ovf_early", ref_overflow, 1'b0);
        wait_to(303);
        check_val("post_ovf", ref_overflow, 1'b1);
        check_val("post_urgent_hold", ref_urgent, 1'b1);
        check_val("post_busy", ref_busy, 1'b0);
        check_val("post_no_cmds", cmd_q.size(), 0);

        // Drain three pending refreshes back to back
        wait_to(308);
        ref_grant = 1'b1;
        wait_to(309);
        check_val("drain_busy_rise", ref_busy, 1'b1);
        wait_to(332);
        check_val("drain_busy_hold", ref_busy, 1'b1);
        wait_to(333);
        check_val("drain_busy_fall", ref_busy, 1'b0);
        check_val("drain_req", ref_req, 1'b0);
        check_val("drain_ovf_sticky", ref_overflow, 1'b1);
        expect_cmd(310, C_PRE);
        expect_cmd(312, C_REF);
        expect_cmd(319, C_REF);
        expect_cmd(326, C_REF);
        check_cmds("drain_cmd");
`ifdef DDR_REFRESH_STATS_EN
        check_val("stat_ref_count", stat_ref_count, 32'd4);
        check_val("stat_max_pending", stat_max_pending, 4'd3);
`endif

        // Reset pulse during the DLL-reset MRS wait aborts and reruns init
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        cmd_q.delete();
        wait_to(16);
        nreset = 1'b0;
        @(negedge clk);
        check_val("abort_cke", cke, 1'b0);
        check_val("abort_init_done", init_done, 1'b0);
        check_val("abort_req", ref_req, 1'b0);
        check_val("abort_busy", ref_busy, 1'b1);
        check_val("abort_valid", cmd_valid, 1'b0);
        cmd_q.delete();
        nreset = 1'b1;
        check_init("reinit");
        check_val("reinit_ovf", ref_overflow, 1'b0);
`ifdef DDR_REFRESH_STATS_EN
        check_val("reinit_stat_count", stat_ref_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr_init_refresh_sched.md
Name: ddr_init_refresh_sched

Overview:
- Sequences the DDR SDRAM (AS4C16M16D1-class, 2 BA bits, 14 A bits) through the JEDEC power-up/mode-register init.
- Afterwards schedules periodic auto-refresh and arbitrates DDR command-bus ownership with the main read/write controller through a req/grant handshake.
- Sits between the SoC memory controller and the DDR PHY command mux; the PHY uses this block's command whenever cmd_valid=1.

Parameters:
- INIT_WAIT_CYCLES, 20000, cycles with CKE low after reset (200 us at 100 MHz)
- TRP_CYCLES, 2, min cycles from PRECHARGE-ALL to next command
- TMRD_CYCLES, 2, min cycles from MRS/EMRS to next command
- TRFC_CYCLES, 7, min cycles from REFRESH to next command
- DLL_LOCK_CYCLES, 200, cycles after final MRS before init_done
- REFI_CYCLES, 780, refresh interval (7.8 us at 100 MHz)
- MAX_POSTPONE, 8, max pending refreshes (1..15)
- MODE_REG, 14'h0021, MRS value (BL2, sequential, CL2); A8 is forced for DLL reset
- EXT_MODE_REG, 14'h0000, EMRS value

Ports:
- clk  in  1  system clock
- nreset  in  1  synchronous active-low reset
- init_done  out  1  init complete; main controller may issue commands
- ref_req  out  1  refresh pending (pending!=0)
- ref_urgent  out  1  pending==MAX_POSTPONE
- ref_grant  in  1  main controller idle, banks closed, bus yielded
- ref_busy  out  1  block owns the command bus
- ref_overflow  out  1  sticky: interval expired while pending==MAX_POSTPONE
- cmd_valid  out  1  one-cycle strobe, command below is real
- cmd_ras_n, cmd_cas_n, cmd_we_n  out  1 each  command encoding
- cmd_ba  out  2  bank address
- cmd_a  out  14  address/mode bits
- cke  out  1  clock enable

Behaviour:
- Encodings: NOP=111, PRECHARGE=010 with A10=1 (all banks), REFRESH=001, MRS/EMRS=000. When cmd_valid=0, outputs are NOP with ba=0 and a=0.
- Reset values (nreset=0 at a clk edge): cke=0, init_done=0, ref_busy=1, ref_req=0, ref_urgent=0, ref_overflow=0, cmd_valid=0, pending=0, interval timer=0, state=RST_WAIT.
- Reset asserted mid-sequence aborts at once and the full init reruns.
- Spacing rule: if a command issues at cycle t, the next command issues at t+Tx exactly, where Tx is the parameter for the first command.
- Init FSM:
  - RST_WAIT: hold INIT_WAIT_CYCLES, then cke=1.
  - CKE_NOP: one NOP cycle.
  - PRE1 (tRP).
  - EMRS: ba=01, a=EXT_MODE_REG (tMRD).
  - MRS_DLLRST: ba=00, a=MODE_REG|14'h0100 (tMRD).
  - PRE2 (tRP).
  - REF1 (tRFC).
  - REF2 (tRFC).
  - MRS: a=MODE_REG.
  - DLL_WAIT: DLL_LOCK_CYCLES, then IDLE. init_done rises on entering IDLE and stays high until reset; ref_busy falls with it.
- Interval timer: starts at IDLE entry and runs continuously afterwards, including during refreshes. On reaching REFI_CYCLES-1 it wraps to 0 and increments pending.
  - If pending==MAX_POSTPONE at expiry, pending holds and ref_overflow sets.
  - Increment and decrement in the same cycle: pending unchanged.
- Refresh FSM: IDLE, then RPRE, then RREF, then RWAIT.
  - In IDLE with ref_req=1 and ref_grant=1: ref_busy=1 next cycle, then PRECHARGE-ALL, wait tRP, REFRESH, wait tRFC.
  - pending decrements in the cycle REFRESH issues.
  - At the end of RWAIT, if pending!=0 and ref_grant=1, issue another REFRESH with no precharge. Otherwise return to IDLE with ref_busy=0.
  - ref_grant deasserting mid-sequence is ignored until RWAIT ends.
- ref_busy is registered; the main controller must not drive the bus while ref_busy=1.

Optional Feature:
- DDR_REFRESH_STATS_EN defined: adds outputs stat_ref_count (32-bit, wraps, counts REFRESH commands after init) and stat_max_pending (4-bit, highest pending value seen). Both reset to 0.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Params INIT=10, TRP=2, TMRD=2, TRFC=7, DLL=20, REFI=50, MAX=3; release reset at cycle 0 -> cke rises at cycle 10. Commands at cycles 11 PRE, 13 EMRS(ba=1), 15 MRS(a=0x0121), 17 PRE, 19 REF, 26 REF, 33 MRS(a=0x0021). init_done=1 at cycle 53.
- Hold ref_grant=1 -> ref_req rises 50 cycles after init_done. PRE then REF 2 cycles later; ref_busy high for exactly 1+2+7 cycles; pending returns to 0.
- Hold ref_grant=0 for 200 cycles after init -> pending=3 and ref_urgent=1 by cycle +150. Expiry at cycle +200 sets ref_overflow; pending stays 3.
- With pending=3, assert ref_grant -> one PRE then 3 REFs spaced 7 cycles apart; ref_busy drops after the last tRFC; ref_overflow stays 1.
- Pulse nreset low during MRS_DLLRST wait -> next cycle cke=0, init_done=0, pending=0; the full init sequence repeats with identical timing.
- With DDR_REFRESH_STATS_EN after the previous scenario -> stat_ref_count=4 (includes scenario 2 REF), stat_max_pending=3.
